// File: rtl/dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | dmem_ctrl: MEM-stage data-memory controller (ld/st, RMW, misalign flag).  |
// | Build option: DMEM_SUBWORD_EN enables byte/half loads and RMW stores.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module dmem_ctrl #(
  parameter int RAM_WIDTH  = 32,
  parameter int ADDR_W     = 11,
  parameter int RD_LATENCY = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_req_valid,
  input  logic                 i_req_we,
  input  logic [1:0]           i_req_size,
  input  logic                 i_req_signed,
  input  logic [31:0]          i_req_addr,
  input  logic [RAM_WIDTH-1:0] i_req_wdata,
  output logic                 o_ready,
  output logic [RAM_WIDTH-1:0] o_rdata,
  output logic                 o_rdata_valid,
  output logic                 o_misaligned,
  output logic [ADDR_W-1:0]    o_ram_addra,
  output logic [RAM_WIDTH-1:0] o_ram_dina,
  output logic                 o_ram_wea,
  output logic                 o_ram_ena,
  output logic                 o_ram_regcea,
  output logic                 o_ram_rsta,
  input  logic [RAM_WIDTH-1:0] i_ram_douta
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] C_LAT   = 2'(RD_LATENCY);

  logic [2:0]           state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [RAM_WIDTH-1:0] rdata_q, rdata_d;
  logic                 rvalid_q, rvalid_d;
  logic                 mis_q, mis_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [RAM_WIDTH-1:0] dina_q, dina_d;
  logic                 wea_q, wea_d;
  logic                 ena_q, ena_d;
  logic                 regce_q, regce_d;
  logic                 rsta_q;
  logic                 w_mis;

  always_comb begin
    case (i_req_size)
`ifdef DMEM_SUBWORD_EN
      SZ_BYTE: w_mis = 1'b0;
      SZ_HALF: w_mis = i_req_addr[0];
`endif
      SZ_WORD: w_mis = |i_req_addr[1:0];
      default: w_mis = 1'b1;
    endcase
  end

`ifdef DMEM_SUBWORD_EN
  logic                 we_q, we_d;
  logic [1:0]           size_q, size_d;
  logic                 signed_q, signed_d;
  logic [1:0]           lane_q, lane_d;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [RAM_WIDTH-1:0] w_load_ext;
  logic [RAM_WIDTH-1:0] w_merged;
  logic                 w_unused_addr;

  assign w_unused_addr = ^i_req_addr[31:ADDR_W+2];

  // Lane extraction for loads and lane insertion for the RMW write-back.
  always_comb begin
    w_byte   = i_ram_douta[8*lane_q +: 8];
    w_half   = i_ram_douta[16*lane_q[1] +: 16];
    w_merged = i_ram_douta;
    case (size_q)
      SZ_BYTE: begin
        w_load_ext             = {{(RAM_WIDTH-8){signed_q & w_byte[7]}}, w_byte};
        w_merged[8*lane_q +: 8] = dina_q[7:0];
      end
      SZ_HALF: begin
        w_load_ext                   = {{(RAM_WIDTH-16){signed_q & w_half[15]}}, w_half};
        w_merged[16*lane_q[1] +: 16] = dina_q[15:0];
      end
      default: w_load_ext = i_ram_douta;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      signed_q <= 1'b0;
      lane_q   <= 2'b00;
    end else begin
      we_q     <= we_d;
      size_q   <= size_d;
      signed_q <= signed_d;
      lane_q   <= lane_d;
    end
  end
`else
  logic w_unused_bits;

  assign w_unused_bits = ^{i_req_addr[31:ADDR_W+2], i_req_signed};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_d  = ready_q;
    rdata_d  = rdata_q;
    addr_d   = addr_q;
    dina_d   = dina_q;
    rvalid_d = 1'b0;
    mis_d    = 1'b0;
    wea_d    = 1'b0;
    ena_d    = 1'b0;
    regce_d  = 1'b0;
`ifdef DMEM_SUBWORD_EN
    we_d     = we_q;
    size_d   = size_q;
    signed_d = signed_q;
    lane_d   = lane_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_req_valid) begin
          addr_d = i_req_addr[ADDR_W+1:2];
          dina_d = i_req_wdata;
`ifdef DMEM_SUBWORD_EN
          we_d     = i_req_we;
          size_d   = i_req_size;
          signed_d = i_req_signed;
          lane_d   = i_req_addr[1:0];
`endif
          if (w_mis) begin
            mis_d = 1'b1;
          end else begin
            ready_d = 1'b0;
            if (i_req_we && i_req_size == SZ_WORD) begin
              state_d = S_WRITE;
              wea_d   = 1'b1;
            end else begin
              state_d = S_READ;
              ena_d   = 1'b1;
            end
          end
        end
      end
      S_READ: begin
        state_d = S_WAIT;
        cnt_d   = C_LAT;
        regce_d = 1'b1;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 2'd1;
        // Last wait cycle: RAM output is valid now and gets captured.
        if (cnt_q == 2'd1) begin
`ifdef DMEM_SUBWORD_EN
          if (we_q) begin
            dina_d  = w_merged;
            wea_d   = 1'b1;
            state_d = S_WRITE;
          end else begin
            rdata_d  = w_load_ext;
            rvalid_d = 1'b1;
            state_d  = S_DONE;
          end
`else
          rdata_d  = i_ram_douta;
          rvalid_d = 1'b1;
          state_d  = S_DONE;
`endif
        end else begin
          regce_d = 1'b1;
        end
      end
      S_WRITE, S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= 2'd0;
      ready_q  <= 1'b1;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      mis_q    <= 1'b0;
      addr_q   <= '0;
      dina_q   <= '0;
      wea_q    <= 1'b0;
      ena_q    <= 1'b0;
      regce_q  <= 1'b0;
      rsta_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mis_q    <= mis_d;
      addr_q   <= addr_d;
      dina_q   <= dina_d;
      wea_q    <= wea_d;
      ena_q    <= ena_d;
      regce_q  <= regce_d;
      rsta_q   <= 1'b0;
    end
  end

  assign o_ready       = ready_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = rvalid_q;
  assign o_misaligned  = mis_q;
  assign o_ram_addra   = addr_q;
  assign o_ram_dina    = dina_q;
  assign o_ram_wea     = wea_q;
  assign o_ram_ena     = ena_q;
  assign o_ram_regcea  = regce_q;
  assign o_ram_rsta    = rsta_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_dmem_ctrl: scoreboard bench, DUT0 RD_LATENCY=2 and DUT1 RD_LATENCY=1.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_dmem_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, preload;
  logic        req_valid, req_we, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;

  logic        rdy0, rv0, mis0, wea0, ena0, rce0, rst0;
  logic [31:0] rd0, din0, dout0, st0;
  logic [10:0] ad0;
  logic        rdy1, rv1, mis1, wea1, ena1, rce1, rst1;
  logic [31:0] rd1, din1, dout1;
  logic [10:0] ad1;

  logic [31:0] mem0 [0:2047];
  logic [31:0] mem1 [0:2047];

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [31:0] data;
    int          acc;
    int          lat;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  dmem_ctrl #(.RAM_WIDTH(32), .ADDR_W(11), .RD_LATENCY(2)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_ready(rdy0), .o_rdata(rd0), .o_rdata_valid(rv0),
    .o_misaligned(mis0), .o_ram_addra(ad0), .o_ram_dina(din0), .o_ram_wea(wea0),
    .o_ram_ena(ena0), .o_ram_regcea(rce0), .o_ram_rsta(rst0), .i_ram_douta(dout0)
  );

  dmem_ctrl #(.RAM_WIDTH(32), .ADDR_W(11), .RD_LATENCY(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_req_size(req_size), .i_req_signed(req_signed), .i_req_addr(req_addr),
    .i_req_wdata(req_wdata), .o_ready(rdy1), .o_rdata(rd1), .o_rdata_valid(rv1),
    .o_misaligned(mis1), .o_ram_addra(ad1), .o_ram_dina(din1), .o_ram_wea(wea1),
    .o_ram_ena(ena1), .o_ram_regcea(rce1), .o_ram_rsta(rst1), .i_ram_douta(dout1)
  );

  // RAM models: write on wea alone; DUT0 has a second output register stage.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (preload) begin
      for (int i = 0; i < 2048; i++) begin
        mem0[i] <= 32'(i);
        mem1[i] <= 32'(i);
      end
    end else begin
      if (wea0) mem0[ad0] <= din0;
      if (ena0) st0 <= mem0[ad0];
      if (rce0) dout0 <= st0;
      if (wea1) mem1[ad1] <= din1;
      if (ena1) dout1 <= mem1[ad1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic exp_mis(input logic [1:0] sz, input logic [31:0] a);
`ifdef DMEM_SUBWORD_EN
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return 1'b1;
    endcase
`else
    return !(sz == 2'b10 && a[1:0] == 2'b00);
`endif
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    if (rv0) begin
      check("rv0_pending", 32'(q0.size() > 0), 32'd1);
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check("rdata0", rd0, e.data);
        check("lat0", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
    if (rv1) begin
      check("rv1_pending", 32'(q1.size() > 0), 32'd1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check("rdata1", rd1, e.data);
        check("lat1", 32'(cyc - e.acc), 32'(e.lat));
      end
    end
  end

  task automatic wait_idle(input string tag);
    int t = 0;
    while (!(rdy0 && rdy1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_idle"}, 32'(rdy0 && rdy1), 32'd1);
  endtask

  // Issue one request to both DUTs and check handshake/RAM-strobe timing.
  task automatic do_req(input string tag, input logic we, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input logic [31:0] expd);
    logic mis;
    int w0 = -1, w1 = -1, r0 = -1, r1 = -1, m0 = 0, m1 = 0, e0 = 0, e1 = 0;
    int xw0, xw1, xr0, xr1, xe;
    wait_idle(tag);
    mis = exp_mis(sz, a);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    if (!we && !mis) begin
      q0.push_back('{expd, cyc, 4});
      q1.push_back('{expd, cyc, 3});
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        req_valid = 1'b0;
        m0 = int'(mis0);
        m1 = int'(mis1);
      end
      if (wea0 && w0 < 0) w0 = k;
      if (wea1 && w1 < 0) w1 = k;
      if (rdy0 && r0 < 0) r0 = k;
      if (rdy1 && r1 < 0) r1 = k;
      e0 += int'(ena0);
      e1 += int'(ena1);
    end
    if (mis) begin
      xw0 = -1; xw1 = -1; xr0 = 1; xr1 = 1; xe = 0;
    end else if (we && sz == 2'b10) begin
      xw0 = 1; xw1 = 1; xr0 = 2; xr1 = 2; xe = 0;
    end else if (we) begin
      xw0 = 4; xw1 = 3; xr0 = 5; xr1 = 4; xe = 1;
    end else begin
      xw0 = -1; xw1 = -1; xr0 = 5; xr1 = 4; xe = 1;
    end
    check({tag, "_mis0"}, 32'(m0), 32'(mis));
    check({tag, "_mis1"}, 32'(m1), 32'(mis));
    check({tag, "_wea_cyc0"}, 32'(w0), 32'(xw0));
    check({tag, "_wea_cyc1"}, 32'(w1), 32'(xw1));
    check({tag, "_rdy_cyc0"}, 32'(r0), 32'(xr0));
    check({tag, "_rdy_cyc1"}, 32'(r1), 32'(xr1));
    check({tag, "_ena_cnt0"}, 32'(e0), 32'(xe));
    check({tag, "_ena_cnt1"}, 32'(e1), 32'(xe));
  endtask

  task automatic reset_midop();
    logic seen_w = 1'b0, seen_v = 1'b0;
    wait_idle("rst_mid");
`ifdef DMEM_SUBWORD_EN
    req_we = 1'b1; req_size = 2'b00; req_addr = 32'h41; req_wdata = 32'h55;
`else
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h40; req_wdata = 32'h0;
`endif
    req_signed = 1'b0;
    req_valid  = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_in_wait", 32'(rce0 && rce1), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 32'({rdy0, rdy1}), 32'h3);
    check("rst_mid_strobes", 32'({ena0, wea0, rce0, rv0, ena1, wea1, rce1, rv1}), 32'h0);
    check("rst_mid_rsta", 32'({rst0, rst1}), 32'h3);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      seen_w = seen_w | wea0 | wea1;
      seen_v = seen_v | rv0 | rv1;
    end
    check("rst_mid_no_wea", 32'(seen_w), 32'd0);
    check("rst_mid_no_valid", 32'(seen_v), 32'd0);
    check("rst_mid_ready_after", 32'({rdy0, rdy1}), 32'h3);
    check("rst_mid_rsta_after", 32'({rst0, rst1}), 32'h0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; preload = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0;
    @(negedge clk);
    check("rst_ready", 32'({rdy0, rdy1}), 32'h3);
    check("rst_rdata", rd0 | rd1, 32'h0);
    check("rst_flags", 32'({rv0, mis0, ena0, wea0, rce0, rv1, mis1, ena1, wea1, rce1}), 32'h0);
    check("rst_ram_bus", 32'(ad0 | ad1) | din0 | din1, 32'h0);
    check("rst_rsta", 32'({rst0, rst1}), 32'h3);
    @(negedge clk);
    preload = 1'b0;
    rst_n   = 1'b1;
    @(negedge clk);
    check("rsta_released", 32'({rst0, rst1}), 32'h0);

    do_req("ldw_10",   1'b0, 2'b10, 1'b0, 32'h10,   32'h0, 32'h00000004);
    do_req("ldw_wrap", 1'b0, 2'b10, 1'b0, 32'h2010, 32'h0, 32'h00000004);
    do_req("stw_20",   1'b1, 2'b10, 1'b0, 32'h20,   32'hDEADBEEF, 32'h0);
    do_req("ldw_20",   1'b0, 2'b10, 1'b0, 32'h20,   32'h0, 32'hDEADBEEF);
    do_req("ldh_23",   1'b0, 2'b01, 1'b0, 32'h23,   32'h0, 32'h0);
    do_req("ldw_22",   1'b0, 2'b10, 1'b0, 32'h22,   32'h0, 32'h0);
    do_req("sz11_24",  1'b0, 2'b11, 1'b0, 32'h24,   32'h0, 32'h0);
`ifdef DMEM_SUBWORD_EN
    do_req("stb_21",   1'b1, 2'b00, 1'b0, 32'h21,   32'h00000080, 32'h0);
    do_req("ldbs_21",  1'b0, 2'b00, 1'b1, 32'h21,   32'h0, 32'hFFFFFF80);
    do_req("ldbu_21",  1'b0, 2'b00, 1'b0, 32'h21,   32'h0, 32'h00000080);
    do_req("ldw_20b",  1'b0, 2'b10, 1'b0, 32'h20,   32'h0, 32'hDEAD80EF);
    do_req("ldbu_23",  1'b0, 2'b00, 1'b0, 32'h23,   32'h0, 32'h000000DE);
    do_req("ldbs_22",  1'b0, 2'b00, 1'b1, 32'h22,   32'h0, 32'hFFFFFFAD);
    do_req("ldhs_20",  1'b0, 2'b01, 1'b1, 32'h20,   32'h0, 32'hFFFF80EF);
    do_req("sth_32",   1'b1, 2'b01, 1'b0, 32'h32,   32'hFFFF1234, 32'h0);
    do_req("ldw_30",   1'b0, 2'b10, 1'b0, 32'h30,   32'h0, 32'h1234000C);
    do_req("ldhs_32",  1'b0, 2'b01, 1'b1, 32'h32,   32'h0, 32'h00001234);
`else
    do_req("ldb_20",   1'b0, 2'b00, 1'b0, 32'h20,   32'h0, 32'h0);
    do_req("ldh_20",   1'b0, 2'b01, 1'b1, 32'h20,   32'h0, 32'h0);
    do_req("stb_21",   1'b1, 2'b00, 1'b0, 32'h21,   32'h80, 32'h0);
    do_req("ldw_20c",  1'b0, 2'b10, 1'b0, 32'h20,   32'h0, 32'hDEADBEEF);
`endif
    reset_midop();
    do_req("ldw_40",   1'b0, 2'b10, 1'b0, 32'h40,   32'h0, 32'h00000010);

    repeat (4) @(negedge clk);
    check("q0_drained", 32'(q0.size()), 32'd0);
    check("q1_drained", 32'(q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
